// File: rtl/snes_map_pkg.sv
// Shared types and constants for the cartridge mapper arbiter: FSM encoding,
// mapper channel indices and the idle CPU/ROM/BSRAM bus pattern.
package snes_map_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SWITCH = 2'd2
   } map_state_t;

   localparam int CH_DLH     = 0;
   localparam int CH_CX4     = 1;
   localparam int CH_SDD1    = 2;
   localparam int CH_GSU     = 3;
   localparam int CH_SA1     = 4;
   localparam int CH_SPC7110 = 5;

   typedef struct packed {
      logic [7:0] di;
      logic       irq_n;
      logic       rom_ce_n;
      logic       rom_oe_n;
      logic       rom_word;
      logic       bsram_ce_n;
      logic       bsram_oe_n;
      logic       bsram_we_n;
   } bus_ctl_t;

   // Open-bus read data, no IRQ, every strobe released.
   localparam bus_ctl_t IDLE_CTL = '{
      di:         8'hFF,
      irq_n:      1'b1,
      rom_ce_n:   1'b1,
      rom_oe_n:   1'b1,
      rom_word:   1'b0,
      bsram_ce_n: 1'b1,
      bsram_oe_n: 1'b1,
      bsram_we_n: 1'b1
   };

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/map_sel_dec.sv
// Decodes the mapper request lines into a channel index; bit k-1 asks for
// channel k, no request means channel 0 and several requests flag an error.
module map_sel_dec #(
   parameter int NCH = 6
) (
   input  logic [NCH-2:0]         map_active,
   output logic [$clog2(NCH)-1:0] req_sel,
   output logic                   multi
);

   localparam int SEL_W = $clog2(NCH);

   logic hit;

   always_comb begin
      req_sel = '0;
      multi   = 1'b0;
      hit     = 1'b0;
      for (int k = 0; k < NCH - 1; k++) begin
         if (map_active[k]) begin
            if (hit) multi = 1'b1;
            hit     = 1'b1;
            req_sel = SEL_W'(k + 1);
         end
      end
      // A conflicting request falls back to the default channel.
      if (multi) req_sel = '0;
   end

endmodule

// File: rtl/cart_map_arb.sv
// Multiplexes the cartridge mapper channels onto one registered bus and
// inserts an idle drain window whenever the active mapper changes.
module cart_map_arb
   import snes_map_pkg::*;
#(
   parameter int             NCH           = 6,
   parameter int             ROM_AW        = 24,
   parameter int             BSRAM_AW      = 20,
   parameter int             DRAIN_CYC     = 4,
   parameter logic [NCH-1:0] NO_TURBO_MASK = 6'b001100
) (
   input  logic                    mclk,
   input  logic                    rst,
   input  logic [NCH-2:0]          map_active,
   input  logic [8*NCH-1:0]        ch_do,
   input  logic [NCH-1:0]          ch_irq_n,
   input  logic [ROM_AW*NCH-1:0]   ch_rom_addr,
   input  logic [NCH-1:0]          ch_rom_ce_n,
   input  logic [NCH-1:0]          ch_rom_oe_n,
   input  logic [NCH-1:0]          ch_rom_word,
   input  logic [BSRAM_AW*NCH-1:0] ch_bsram_addr,
   input  logic [8*NCH-1:0]        ch_bsram_d,
   input  logic [NCH-1:0]          ch_bsram_ce_n,
   input  logic [NCH-1:0]          ch_bsram_oe_n,
   input  logic [NCH-1:0]          ch_bsram_we_n,
   output logic [7:0]              di,
   output logic                    irq_n,
   output logic [ROM_AW-1:0]       rom_addr,
   output logic                    rom_ce_n,
   output logic                    rom_oe_n,
   output logic                    rom_word,
   output logic [BSRAM_AW-1:0]     bsram_addr,
   output logic [7:0]              bsram_d,
   output logic                    bsram_ce_n,
   output logic                    bsram_oe_n,
   output logic                    bsram_we_n,
   output logic                    turbo_allow,
   output logic [$clog2(NCH)-1:0]  cur_sel,
   output logic                    switching,
   output logic                    err_multi,
   output logic [7:0]              switch_cnt
);

   localparam int SEL_W = $clog2(NCH);
   localparam int CNT_W = $clog2(4 * DRAIN_CYC);

   logic [SEL_W-1:0]    req_sel;
   logic                multi;
   map_state_t          state, state_d;
   logic [SEL_W-1:0]    cur_sel_d, tgt_sel, tgt_sel_d;
   logic [CNT_W-1:0]    drain_cnt, drain_cnt_d;
   logic                count_switch;
   logic                old_idle;
   bus_ctl_t            ctl_q;
   bus_ctl_t            ch_ctl  [NCH];
   logic [ROM_AW-1:0]   ch_ra   [NCH];
   logic [BSRAM_AW-1:0] ch_ba   [NCH];
   logic [7:0]          ch_bd   [NCH];

   map_sel_dec #(.NCH(NCH)) u_dec (
      .map_active (map_active),
      .req_sel    (req_sel),
      .multi      (multi)
   );

   for (genvar k = 0; k < NCH; k++) begin : g_unpack
      assign ch_ctl[k] = '{
         di:         ch_do[8*k +: 8],
         irq_n:      ch_irq_n[k],
         rom_ce_n:   ch_rom_ce_n[k],
         rom_oe_n:   ch_rom_oe_n[k],
         rom_word:   ch_rom_word[k],
         bsram_ce_n: ch_bsram_ce_n[k],
         bsram_oe_n: ch_bsram_oe_n[k],
         bsram_we_n: ch_bsram_we_n[k]
      };
      assign ch_ra[k] = ch_rom_addr[ROM_AW*k +: ROM_AW];
      assign ch_ba[k] = ch_bsram_addr[BSRAM_AW*k +: BSRAM_AW];
      assign ch_bd[k] = ch_bsram_d[8*k +: 8];
   end

   // The outgoing mapper may only be cut early once it has released both chip enables.
   assign old_idle = ch_rom_ce_n[cur_sel] & ch_bsram_ce_n[cur_sel];

   always_comb begin
      state_d      = state;
      cur_sel_d    = cur_sel;
      tgt_sel_d    = tgt_sel;
      drain_cnt_d  = drain_cnt;
      count_switch = 1'b0;
      case (state)
         ST_RUN: begin
            if (req_sel != cur_sel) begin
               state_d     = ST_DRAIN;
               tgt_sel_d   = req_sel;
               drain_cnt_d = '0;
            end
         end
         ST_DRAIN: begin
            if (req_sel == cur_sel) begin
               state_d = ST_RUN;
            end else if (req_sel != tgt_sel) begin
               tgt_sel_d   = req_sel;
               drain_cnt_d = '0;
            end else if ((drain_cnt >= CNT_W'(DRAIN_CYC - 1) && old_idle) ||
                         drain_cnt == CNT_W'(4 * DRAIN_CYC - 1)) begin
               state_d = ST_SWITCH;
            end else begin
               drain_cnt_d = drain_cnt + 1'b1;
            end
         end
         ST_SWITCH: begin
            state_d      = ST_RUN;
            cur_sel_d    = req_sel;
            count_switch = 1'b1;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Bus registers follow the state being entered, so outputs lag inputs by one mclk.
   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         state       <= ST_RUN;
         cur_sel     <= '0;
         tgt_sel     <= '0;
         drain_cnt   <= '0;
         ctl_q       <= IDLE_CTL;
         rom_addr    <= '0;
         bsram_addr  <= '0;
         bsram_d     <= '0;
         turbo_allow <= 1'b1;
         switching   <= 1'b0;
         err_multi   <= 1'b0;
         switch_cnt  <= '0;
      end else begin
         state       <= state_d;
         cur_sel     <= cur_sel_d;
         tgt_sel     <= tgt_sel_d;
         drain_cnt   <= drain_cnt_d;
         switching   <= (state_d != ST_RUN);
         turbo_allow <= (state_d == ST_RUN) ? ~NO_TURBO_MASK[cur_sel_d] : 1'b0;
         err_multi   <= err_multi | multi;
         if (count_switch) switch_cnt <= sat_inc8(switch_cnt);
         if (state_d == ST_RUN) begin
            ctl_q      <= ch_ctl[cur_sel_d];
            rom_addr   <= ch_ra[cur_sel_d];
            bsram_addr <= ch_ba[cur_sel_d];
            bsram_d    <= ch_bd[cur_sel_d];
         end else begin
            ctl_q      <= IDLE_CTL;
         end
      end
   end

   assign di         = ctl_q.di;
   assign irq_n      = ctl_q.irq_n;
   assign rom_ce_n   = ctl_q.rom_ce_n;
   assign rom_oe_n   = ctl_q.rom_oe_n;
   assign rom_word   = ctl_q.rom_word;
   assign bsram_ce_n = ctl_q.bsram_ce_n;
   assign bsram_oe_n = ctl_q.bsram_oe_n;
   assign bsram_we_n = ctl_q.bsram_we_n;

endmodule

// File: tb/tb_cart_map_arb.sv
// Self-checking bench for cart_map_arb: channel-0 pass-through vectors from a
// table, then hand-written switch, timeout, revert, multi-hot and reset sequences.
module tb_cart_map_arb;
   import snes_map_pkg::*;

   localparam int NCH       = 6;
   localparam int ROM_AW    = 24;
   localparam int BSRAM_AW  = 20;
   localparam int DRAIN_CYC = 4;
   // SA1 and SDD1 forbid turbo: bits 4 and 2 -> 6'b010100.
   localparam logic [NCH-1:0] TB_MASK = 6'(1 << CH_SA1) | 6'(1 << CH_SDD1);

   logic                    mclk;
   logic                    rst;
   logic [NCH-2:0]          map_active;
   logic [8*NCH-1:0]        ch_do;
   logic [NCH-1:0]          ch_irq_n;
   logic [ROM_AW*NCH-1:0]   ch_rom_addr;
   logic [NCH-1:0]          ch_rom_ce_n, ch_rom_oe_n, ch_rom_word;
   logic [BSRAM_AW*NCH-1:0] ch_bsram_addr;
   logic [8*NCH-1:0]        ch_bsram_d;
   logic [NCH-1:0]          ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n;
   logic [7:0]              di;
   logic                    irq_n;
   logic [ROM_AW-1:0]       rom_addr;
   logic                    rom_ce_n, rom_oe_n, rom_word;
   logic [BSRAM_AW-1:0]     bsram_addr;
   logic [7:0]              bsram_d;
   logic                    bsram_ce_n, bsram_oe_n, bsram_we_n;
   logic                    turbo_allow;
   logic [2:0]              cur_sel;
   logic                    switching;
   logic                    err_multi;
   logic [7:0]              switch_cnt;
   logic [5:0]              stb_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0]  d0;
      logic [7:0]  d1;
      logic        irq0;
      logic [5:0]  stb0;
      logic [23:0] ra0;
      logic [7:0]  exp_di;
      logic        exp_irq;
      logic [5:0]  exp_stb;
      logic [23:0] exp_ra;
   } vec_t;

   vec_t vecs [4];

   cart_map_arb #(
      .NCH           (NCH),
      .ROM_AW        (ROM_AW),
      .BSRAM_AW      (BSRAM_AW),
      .DRAIN_CYC     (DRAIN_CYC),
      .NO_TURBO_MASK (TB_MASK)
   ) dut (
      .mclk          (mclk),
      .rst           (rst),
      .map_active    (map_active),
      .ch_do         (ch_do),
      .ch_irq_n      (ch_irq_n),
      .ch_rom_addr   (ch_rom_addr),
      .ch_rom_ce_n   (ch_rom_ce_n),
      .ch_rom_oe_n   (ch_rom_oe_n),
      .ch_rom_word   (ch_rom_word),
      .ch_bsram_addr (ch_bsram_addr),
      .ch_bsram_d    (ch_bsram_d),
      .ch_bsram_ce_n (ch_bsram_ce_n),
      .ch_bsram_oe_n (ch_bsram_oe_n),
      .ch_bsram_we_n (ch_bsram_we_n),
      .di            (di),
      .irq_n         (irq_n),
      .rom_addr      (rom_addr),
      .rom_ce_n      (rom_ce_n),
      .rom_oe_n      (rom_oe_n),
      .rom_word      (rom_word),
      .bsram_addr    (bsram_addr),
      .bsram_d       (bsram_d),
      .bsram_ce_n    (bsram_ce_n),
      .bsram_oe_n    (bsram_oe_n),
      .bsram_we_n    (bsram_we_n),
      .turbo_allow   (turbo_allow),
      .cur_sel       (cur_sel),
      .switching     (switching),
      .err_multi     (err_multi),
      .switch_cnt    (switch_cnt)
   );

   assign stb_out = {rom_ce_n, rom_oe_n, rom_word, bsram_ce_n, bsram_oe_n, bsram_we_n};

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Channel k reads 0xA0+k, ROM address {k,0x0100}, BSRAM {k,0x0040} / 0x30+k, all strobes idle.
   task automatic setDefaults();
      for (int k = 0; k < NCH; k++) begin
         ch_do[8*k +: 8]                     = 8'hA0 + 8'(k);
         ch_rom_addr[ROM_AW*k +: ROM_AW]     = {8'(k), 16'h0100};
         ch_bsram_addr[BSRAM_AW*k +: BSRAM_AW] = {4'(k), 16'h0040};
         ch_bsram_d[8*k +: 8]                = 8'h30 + 8'(k);
      end
      ch_irq_n      = '1;
      ch_rom_ce_n   = '1;
      ch_rom_oe_n   = '1;
      ch_rom_word   = '0;
      ch_bsram_ce_n = '1;
      ch_bsram_oe_n = '1;
      ch_bsram_we_n = '1;
      map_active    = '0;
   endtask

   task automatic applyStimulus(input vec_t v);
      ch_do[7:0]       = v.d0;
      ch_do[15:8]      = v.d1;
      ch_irq_n[0]      = v.irq0;
      ch_rom_ce_n[0]   = v.stb0[5];
      ch_rom_oe_n[0]   = v.stb0[4];
      ch_rom_word[0]   = v.stb0[3];
      ch_bsram_ce_n[0] = v.stb0[2];
      ch_bsram_oe_n[0] = v.stb0[1];
      ch_bsram_we_n[0] = v.stb0[0];
      ch_rom_addr[23:0] = v.ra0;
   endtask

   // Counts consecutive switching cycles after a request, bounded at 40.
   task automatic countSwitch(input logic [NCH-2:0] ma, output int n);
      map_active = ma;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (switching) n++;
         else break;
      end
   endtask

   initial begin
      int n;

      vecs[0] = '{8'h5A, 8'h11, 1'b1, 6'b110111, 24'h000000, 8'h5A, 1'b1, 6'b110111, 24'h000000};
      vecs[1] = '{8'hA5, 8'h5A, 1'b0, 6'b001111, 24'h123456, 8'hA5, 1'b0, 6'b001111, 24'h123456};
      vecs[2] = '{8'h00, 8'hFF, 1'b1, 6'b110000, 24'hFFFFFF, 8'h00, 1'b1, 6'b110000, 24'hFFFFFF};
      vecs[3] = '{8'hFF, 8'h00, 1'b0, 6'b000000, 24'h800001, 8'hFF, 1'b0, 6'b000000, 24'h800001};

      rst = 1'b1;
      setDefaults();
      #3;
      checkOutput("rst_di",        32'(di),          32'hFF);
      checkOutput("rst_irq",       32'(irq_n),       32'h1);
      checkOutput("rst_strobes",   32'(stb_out),     32'h37);
      checkOutput("rst_rom_addr",  32'(rom_addr),    32'h0);
      checkOutput("rst_bsram_adr", 32'(bsram_addr),  32'h0);
      checkOutput("rst_bsram_d",   32'(bsram_d),     32'h0);
      checkOutput("rst_turbo",     32'(turbo_allow), 32'h1);
      checkOutput("rst_cur_sel",   32'(cur_sel),     32'h0);
      checkOutput("rst_switching", 32'(switching),   32'h0);
      checkOutput("rst_err_multi", 32'(err_multi),   32'h0);
      checkOutput("rst_sw_cnt",    32'(switch_cnt),  32'h0);
      tick();
      tick();
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         applyStimulus(vecs[i]);
         tick();
         checkOutput($sformatf("vec%0d_di", i),       32'(di),          32'(vecs[i].exp_di));
         checkOutput($sformatf("vec%0d_irq", i),      32'(irq_n),       32'(vecs[i].exp_irq));
         checkOutput($sformatf("vec%0d_strobes", i),  32'(stb_out),     32'(vecs[i].exp_stb));
         checkOutput($sformatf("vec%0d_rom_addr", i), 32'(rom_addr),    32'(vecs[i].exp_ra));
         checkOutput($sformatf("vec%0d_cur_sel", i),  32'(cur_sel),     32'h0);
         checkOutput($sformatf("vec%0d_turbo", i),    32'(turbo_allow), 32'h1);
      end

      // Clean drain 0 -> 4 (SA1): 4 DRAIN + 1 SWITCH, addresses held meanwhile.
      setDefaults();
      tick();
      checkOutput("pre_sw_rom_addr", 32'(rom_addr),   32'h000100);
      checkOutput("pre_sw_bsram_d",  32'(bsram_d),    32'h30);
      map_active = 5'b01000;
      tick();
      checkOutput("sw4_c0_switching", 32'(switching),   32'h1);
      checkOutput("sw4_c0_turbo",     32'(turbo_allow), 32'h0);
      checkOutput("sw4_c0_di",        32'(di),          32'hFF);
      checkOutput("sw4_c0_strobes",   32'(stb_out),     32'h37);
      ch_rom_addr[23:0] = 24'h0BEEF0;
      ch_irq_n[0]       = 1'b0;
      for (int i = 1; i < 5; i++) begin
         tick();
         checkOutput($sformatf("sw4_c%0d_switching", i), 32'(switching), 32'h1);
         checkOutput($sformatf("sw4_c%0d_irq", i),       32'(irq_n),     32'h1);
         checkOutput($sformatf("sw4_c%0d_rom_addr", i),  32'(rom_addr),  32'h000100);
      end
      tick();
      checkOutput("sw4_done_switching", 32'(switching),   32'h0);
      checkOutput("sw4_done_cur_sel",   32'(cur_sel),     32'h4);
      checkOutput("sw4_done_turbo",     32'(turbo_allow), 32'h0);
      checkOutput("sw4_done_sw_cnt",    32'(switch_cnt),  32'h1);
      checkOutput("sw4_done_di",        32'(di),          32'hA4);
      checkOutput("sw4_done_rom_addr",  32'(rom_addr),    32'h040100);
      setDefaults();
      map_active = 5'b01000;

      // Old channel 4 keeps ROM enabled: drain only ends at the 16-cycle timeout.
      ch_rom_ce_n[4] = 1'b0;
      countSwitch(5'b00000, n);
      checkOutput("timeout_switch_cycles", 32'(n),           32'd17);
      checkOutput("timeout_cur_sel",       32'(cur_sel),     32'h0);
      checkOutput("timeout_sw_cnt",        32'(switch_cnt),  32'h2);
      checkOutput("timeout_turbo",         32'(turbo_allow), 32'h1);
      checkOutput("timeout_di",            32'(di),          32'hA0);
      ch_rom_ce_n[4] = 1'b1;

      // Request channel 2, then withdraw on the second DRAIN cycle.
      map_active = 5'b00010;
      tick();
      checkOutput("revert_c1_switching", 32'(switching), 32'h1);
      tick();
      checkOutput("revert_c2_switching", 32'(switching), 32'h1);
      map_active = 5'b00000;
      tick();
      checkOutput("revert_switching", 32'(switching),   32'h0);
      checkOutput("revert_cur_sel",   32'(cur_sel),     32'h0);
      checkOutput("revert_sw_cnt",    32'(switch_cnt),  32'h2);
      checkOutput("revert_di",        32'(di),          32'hA0);
      checkOutput("revert_turbo",     32'(turbo_allow), 32'h1);

      // Retarget 3 -> 5 mid-drain restarts the counter: 2 + 4 DRAIN + 1 SWITCH.
      map_active = 5'b00100;
      tick();
      tick();
      countSwitch(5'b10000, n);
      checkOutput("restart_switch_cycles", 32'(n + 2),       32'd7);
      checkOutput("restart_cur_sel",       32'(cur_sel),     32'h5);
      checkOutput("restart_sw_cnt",        32'(switch_cnt),  32'h3);
      checkOutput("restart_turbo",         32'(turbo_allow), 32'h1);
      checkOutput("restart_di",            32'(di),          32'hA5);

      // Multi-hot request: sticky error and a switch to channel 0.
      checkOutput("multi_pre_err", 32'(err_multi), 32'h0);
      countSwitch(5'b00011, n);
      checkOutput("multi_switch_cycles", 32'(n),          32'd5);
      checkOutput("multi_err",           32'(err_multi),  32'h1);
      checkOutput("multi_cur_sel",       32'(cur_sel),    32'h0);
      checkOutput("multi_sw_cnt",        32'(switch_cnt), 32'h4);
      map_active = 5'b00000;
      tick();
      tick();
      checkOutput("multi_err_sticky", 32'(err_multi), 32'h1);
      checkOutput("multi_post_sel",   32'(cur_sel),   32'h0);
      checkOutput("multi_post_sw",    32'(switching), 32'h0);

      // Reset asserted mid-drain takes effect without a clock edge.
      map_active = 5'b00001;
      tick();
      tick();
      checkOutput("rstmid_pre_switching", 32'(switching), 32'h1);
      rst = 1'b1;
      #2;
      checkOutput("rstmid_switching", 32'(switching),   32'h0);
      checkOutput("rstmid_di",        32'(di),          32'hFF);
      checkOutput("rstmid_strobes",   32'(stb_out),     32'h37);
      checkOutput("rstmid_rom_addr",  32'(rom_addr),    32'h0);
      checkOutput("rstmid_turbo",     32'(turbo_allow), 32'h1);
      checkOutput("rstmid_err",       32'(err_multi),   32'h0);
      checkOutput("rstmid_sw_cnt",    32'(switch_cnt),  32'h0);
      checkOutput("rstmid_cur_sel",   32'(cur_sel),     32'h0);
      map_active = 5'b00000;
      tick();
      rst = 1'b0;
      tick();
      checkOutput("rstrel_switching", 32'(switching),   32'h0);
      checkOutput("rstrel_cur_sel",   32'(cur_sel),     32'h0);
      checkOutput("rstrel_di",        32'(di),          32'hA0);
      checkOutput("rstrel_turbo",     32'(turbo_allow), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
